// File: rtl/tile_line_fetcher_if.sv
// Pixel stream from the tile line fetcher to the pixel output stage.
// Data is {palette[3:0], color[1:0]}; pix_last marks the final pixel of a scanline.
interface tile_line_fetcher_if;
  logic       pix_valid;
  logic       pix_ready;
  logic [5:0] pix_data;
  logic       pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/tile_line_fetcher.sv
// Walks one scanline of the tile map through a single BRAM read port and streams
// 2bpp pixels tagged with the tile palette over a valid/ready handshake.
module tile_line_fetcher #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TILES_PER_LINE = 32,
  parameter int unsigned MAP_BASE       = 0,
  parameter int unsigned PAT_BASE       = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line_start,
  input  logic [7:0]            line_y,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_dout,
  tile_line_fetcher_if.master   pix
);

  localparam int unsigned TxW = (TILES_PER_LINE > 1) ? $clog2(TILES_PER_LINE) : 1;
  localparam logic [TxW-1:0] TxLast = TxW'(TILES_PER_LINE - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StMap   = 3'd1;
  localparam logic [2:0] StMapD  = 3'd2;
  localparam logic [2:0] StPat   = 3'd3;
  localparam logic [2:0] StPatD  = 3'd4;
  localparam logic [2:0] StShift = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [7:0]            line_y_q, line_y_d;
  logic [TxW-1:0]        tx_q, tx_d;
  logic [3:0]            pal_q, pal_d;
  logic [15:0]           shreg_q, shreg_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  // Map word bits [15:12] carry no meaning for this block.
  logic unused_map_bits;
  assign unused_map_bits = ^mem_dout[15:12];

  // Both addresses wrap modulo 2^ADDR_WIDTH by truncation.
  function automatic logic [ADDR_WIDTH-1:0] map_addr(logic [4:0] row, logic [TxW-1:0] tx);
    return ADDR_WIDTH'(MAP_BASE + 32'(row) * TILES_PER_LINE + 32'(tx));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] pat_addr(logic [7:0] tile, logic [2:0] fine_y);
    return ADDR_WIDTH'(PAT_BASE + 32'(tile) * 8 + 32'(fine_y));
  endfunction

  always_comb begin
    state_d    = state_q;
    line_y_d   = line_y_q;
    tx_d       = tx_q;
    pal_d      = pal_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      StIdle: begin
        if (line_start) begin
          line_y_d   = line_y;
          tx_d       = '0;
          mem_addr_d = map_addr(line_y[7:3], '0);
          state_d    = StMap;
        end
      end
      StMap:  state_d = StMapD;
      StMapD: begin
        pal_d      = mem_dout[11:8];
        mem_addr_d = pat_addr(mem_dout[7:0], line_y_q[2:0]);
        state_d    = StPat;
      end
      StPat:  state_d = StPatD;
      StPatD: begin
        shreg_d = mem_dout;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (pix.pix_ready) begin
          shreg_d = {shreg_q[13:0], 2'b00};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (tx_q == TxLast) begin
              state_d = StIdle;
            end else begin
              tx_d       = tx_q + 1'b1;
              mem_addr_d = map_addr(line_y_q[7:3], tx_q + 1'b1);
              state_d    = StMap;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      line_y_q   <= '0;
      tx_q       <= '0;
      pal_q      <= '0;
      shreg_q    <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      line_y_q   <= line_y_d;
      tx_q       <= tx_d;
      pal_q      <= pal_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    mem_addr      = mem_addr_q;
    pix.pix_valid = (state_q == StShift);
    pix.pix_data  = pix.pix_valid ? {pal_q, shreg_q[15:14]} : 6'd0;
    pix.pix_last  = pix.pix_valid && (cnt_q == 3'd7) && (tx_q == TxLast);
  end

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Scoreboard bench: stimulus queues expected pixels, a negedge monitor pops and compares
// on every handshake and logs the BRAM address sequence of the selected instance.
module tb_tile_line_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        ls_a = 1'b0, ls_w = 1'b0, pix_ready = 1'b1, sel = 1'b0, bp_en = 1'b0;
  logic [7:0]  line_y = 8'd0;
  logic        busy_a, busy_w;
  logic [11:0] addr_a, addr_w;
  logic [15:0] dout_a, dout_w;
  logic [15:0] mem [4096];

  tile_line_fetcher_if pa ();
  tile_line_fetcher_if pw ();
  assign pa.pix_ready = pix_ready;
  assign pw.pix_ready = pix_ready;

  tile_line_fetcher dut (
    .clk(clk), .rst_n(rst_n), .line_start(ls_a), .line_y(line_y), .busy(busy_a),
    .mem_addr(addr_a), .mem_dout(dout_a), .pix(pa)
  );

  tile_line_fetcher #(.MAP_BASE(4090)) dut_w (
    .clk(clk), .rst_n(rst_n), .line_start(ls_w), .line_y(line_y), .busy(busy_w),
    .mem_addr(addr_w), .mem_dout(dout_w), .pix(pw)
  );

  always @(posedge clk) begin
    dout_a <= mem[addr_a];
    dout_w <= mem[addr_w];
  end

  logic        mv, ml, mbusy;
  logic [5:0]  md;
  logic [11:0] maddr;
  assign mv    = sel ? pw.pix_valid : pa.pix_valid;
  assign ml    = sel ? pw.pix_last  : pa.pix_last;
  assign md    = sel ? pw.pix_data  : pa.pix_data;
  assign mbusy = sel ? busy_w : busy_a;
  assign maddr = sel ? addr_w : addr_a;

  int checks = 0, errors = 0, pix_seen = 0, bp_i = 0;
  logic [6:0]  exp_q[$];
  logic [11:0] addr_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes, stall stability, and BRAM address changes while busy.
  logic       stall_prev = 1'b0, busy_prev = 1'b0;
  logic [6:0] stall_val = '0;
  logic [11:0] addr_prev = '0;
  always @(negedge clk) begin
    logic [6:0] e;
    if (stall_prev) begin
      check("stall_valid", 32'(mv), 32'd1);
      check("stall_data_last", 32'({ml, md}), 32'(stall_val));
    end
    if (mv && pix_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %0h expected none", {ml, md});
      end else begin
        e = exp_q.pop_front();
        check("pix_data", 32'(md), 32'(e[5:0]));
        check("pix_last", 32'(ml), 32'(e[6]));
      end
      pix_seen++;
    end
    stall_prev = mv && !pix_ready;
    stall_val  = {ml, md};
    if (mbusy && (!busy_prev || maddr != addr_prev)) addr_log.push_back(maddr);
    busy_prev = mbusy;
    addr_prev = maddr;
  end

  // Ready pattern 1,0,0,1 while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        pix_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
        bp_i++;
      end else begin
        pix_ready = 1'b1;
      end
    end
  end

  function automatic int map_a(int base, logic [7:0] y, int tx);
    return (base + int'(y[7:3]) * 32 + tx) % 4096;
  endfunction

  function automatic int pat_a(int base, logic [7:0] y, int tx);
    logic [15:0] mw;
    mw = mem[map_a(base, y, tx)];
    return (1024 + int'(mw[7:0]) * 8 + int'(y[2:0])) % 4096;
  endfunction

  function automatic logic [6:0] exp_pix(int base, logic [7:0] y, int tx, int p);
    logic [15:0] mw, pw_, t;
    mw = mem[map_a(base, y, tx)];
    pw_ = mem[pat_a(base, y, tx)];
    t = pw_ >> (14 - 2 * p);
    return {(tx == 31 && p == 7), mw[11:8], t[1:0]};
  endfunction

  task automatic push_model(input int base, input logic [7:0] y, input int first_tx);
    for (int tx = first_tx; tx < 32; tx++)
      for (int p = 0; p < 8; p++) exp_q.push_back(exp_pix(base, y, tx, p));
  endtask

  // Returns one cycle after the accepting edge E0.
  task automatic start_line(input logic w, input logic [7:0] y);
    @(posedge clk);
    #1;
    line_y = y;
    if (w) ls_w = 1'b1; else ls_a = 1'b1;
    @(posedge clk);
    #1;
    ls_a = 1'b0;
    ls_w = 1'b0;
  endtask

  task automatic run_wait(output int cyc, output int first);
    cyc = 0;
    first = -1;
    while (mbusy && cyc < 2000) begin
      if (mv && first < 0) first = cyc;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 2000) begin
      checks++;
      errors++;
      $display("FAIL line_timeout: got busy after %0d cycles expected idle", cyc);
    end
  endtask

  task automatic wait_pixels(input int target);
    int n = 0;
    while (pix_seen < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_pixel_count", 32'(pix_seen >= target), 32'd1);
  endtask

  task automatic check_addrs(input int base, input logic [7:0] y);
    check("addr_log_len", 32'(addr_log.size()), 32'd64);
    for (int tx = 0; tx < 32; tx++) begin
      if (2 * tx + 1 < addr_log.size()) begin
        check("map_addr", 32'(addr_log[2 * tx]), 32'(map_a(base, y, tx)));
        check("pat_addr", 32'(addr_log[2 * tx + 1]), 32'(pat_a(base, y, tx)));
      end
    end
  endtask

  initial begin
    int cyc, first, s0;
    logic [5:0] hv [8];
    hv = '{6'h0F, 6'h0E, 6'h0D, 6'h0C, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    for (int i = 0; i < 4096; i++) mem[i] = 16'((i * 40503 + 12345) & 'hFFFF);
    mem[0]    = 16'h0305;
    mem[1066] = 16'hE41B;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_valid", 32'(pa.pix_valid), 32'd0);
    check("rst_last", 32'(pa.pix_last), 32'd0);
    check("rst_data", 32'(pa.pix_data), 32'd0);
    check("rst_addr", 32'(addr_a), 32'd0);
    rst_n = 1'b1;

    // Single tile row: hand vectors for tile 0, model for the rest.
    for (int p = 0; p < 8; p++) exp_q.push_back({1'b0, hv[p]});
    push_model(0, 8'd2, 1);
    start_line(1'b0, 8'd2);
    check("busy_after_accept", 32'(busy_a), 32'd1);
    run_wait(cyc, first);
    check("first_pix_latency", 32'(first), 32'd4);
    check("line_cycles_y2", 32'(cyc), 32'd384);
    check("queue_empty_y2", 32'(exp_q.size()), 32'd0);

    // Full line addressing.
    addr_log.delete();
    push_model(0, 8'd17, 0);
    start_line(1'b0, 8'd17);
    run_wait(cyc, first);
    check("line_cycles_y17", 32'(cyc), 32'd384);
    check("queue_empty_y17", 32'(exp_q.size()), 32'd0);
    check_addrs(0, 8'd17);

    // Backpressure: same line, ready toggling.
    push_model(0, 8'd17, 0);
    bp_en = 1'b1;
    start_line(1'b0, 8'd17);
    run_wait(cyc, first);
    bp_en = 1'b0;
    check("queue_empty_bp", 32'(exp_q.size()), 32'd0);

    // Request during a running line is dropped.
    s0 = pix_seen;
    push_model(0, 8'd2, 0);
    start_line(1'b0, 8'd2);
    wait_pixels(s0 + 40);
    line_y = 8'd9;
    ls_a = 1'b1;
    @(posedge clk);
    #1;
    ls_a = 1'b0;
    run_wait(cyc, first);
    repeat (10) @(posedge clk);
    #1;
    check("ignored_busy", 32'(busy_a), 32'd0);
    check("ignored_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-line, then a clean line.
    s0 = pix_seen;
    push_model(0, 8'd2, 0);
    start_line(1'b0, 8'd2);
    wait_pixels(s0 + 80);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_valid", 32'(pa.pix_valid), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    check("midrst_addr", 32'(addr_a), 32'd0);
    check("midrst_last", 32'(pa.pix_last), 32'd0);
    exp_q.delete();
    push_model(0, 8'd2, 0);
    start_line(1'b0, 8'd2);
    run_wait(cyc, first);
    check("line_cycles_after_rst", 32'(cyc), 32'd384);
    check("queue_empty_after_rst", 32'(exp_q.size()), 32'd0);

    // Map address wrap on the MAP_BASE=4090 instance.
    sel = 1'b1;
    addr_log.delete();
    push_model(4090, 8'd0, 0);
    start_line(1'b1, 8'd0);
    run_wait(cyc, first);
    check("line_cycles_wrap", 32'(cyc), 32'd384);
    check("queue_empty_wrap", 32'(exp_q.size()), 32'd0);
    check_addrs(4090, 8'd0);
    check("wrap_first_map", 32'(addr_log[0]), 32'd4090);
    check("wrap_seventh_map", 32'(addr_log[12]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
